// File: rtl/exponent_accelerator_pio_in_irq.sv
// Avalon-MM input PIO with synchroniser, per-bit debounce, edge capture and maskable irq.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   address, write,       - 4-word slave: 0 data, 1 irqmask, 2 edgecapture (W1C), 3 raw
//   writedata
//   in_port               - asynchronous external inputs
//   readdata              - registered read data, latency 1, no read strobe needed
//   irq                   - level interrupt, |(edgecapture & irqmask)
module exponent_accelerator_pio_in_irq #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]           meta_q, sync_q;
  logic [WIDTH-1:0]           deb_q, deb_d, deb_dly_q;
  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           irqmask_q, irqmask_d;
  logic [WIDTH-1:0]           cap_q, cap_d;
  logic [WIDTH-1:0]           rise, fall, edge_det, clr_mask;
  logic [31:0]                readdata_q, readdata_d;
  logic                       wr_mask, wr_cap;

  // Upper writedata bits are don't-care when WIDTH < 32.
  logic unused_wd;
  assign unused_wd = ^writedata;

  // A counter reaching DEBOUNCE_CYCLES-1 while still mismatched accepts the new level;
  // any cycle where sync agrees with deb restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        deb_d[i] = sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  assign rise = deb_q & ~deb_dly_q;
  assign fall = ~deb_q & deb_dly_q;

  always_comb begin
    if (EDGE_MODE == 0)      edge_det = rise;
    else if (EDGE_MODE == 1) edge_det = fall;
    else                     edge_det = rise | fall;
  end

  assign wr_mask  = write && (address == 2'd1);
  assign wr_cap   = write && (address == 2'd2);
  assign clr_mask = wr_cap ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irqmask_d = wr_mask ? writedata[WIDTH-1:0] : irqmask_q;
    // New edges are OR-ed in after the clear so a simultaneous set wins.
    cap_d     = (cap_q & ~clr_mask) | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0: readdata_d[WIDTH-1:0] = deb_q;
      2'd1: readdata_d[WIDTH-1:0] = irqmask_q;
      2'd2: readdata_d[WIDTH-1:0] = cap_q;
      2'd3: readdata_d[WIDTH-1:0] = sync_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q     <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      cnt_q      <= '0;
      irqmask_q  <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      meta_q     <= in_port;
      sync_q     <= meta_q;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_q;
      cnt_q      <= cnt_d;
      irqmask_q  <= irqmask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & irqmask_q);

endmodule

// File: tb/tb_exponent_accelerator_pio_in_irq.sv
// Bench for exponent_accelerator_pio_in_irq: a vector table for reset, debounce latency and
// register access, then directed sequences for glitches, set-vs-W1C, any-edge mode and reset.
module tb_exponent_accelerator_pio_in_irq;

  logic        clk;
  // Rising-edge instance
  logic        reset, write, irq;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic [9:0]  in_port;
  // Any-edge instance
  logic        reset2, write2, irq2;
  logic [1:0]  address2;
  logic [31:0] writedata2, readdata2;
  logic [9:0]  in_port2;

  int n_total = 0;
  int n_pass  = 0;

  exponent_accelerator_pio_in_irq #(
    .WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  exponent_accelerator_pio_in_irq #(
    .WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)
  ) dut2 (
    .clk(clk), .reset(reset2), .address(address2), .write(write2), .writedata(writedata2),
    .in_port(in_port2), .readdata(readdata2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [9:0]  inp;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic rst, logic [1:0] addr, logic wr, logic [31:0] wd,
                              logic [9:0] inp, logic [31:0] exp_rd, logic exp_irq);
    vec_t v;
    v.rst = rst; v.addr = addr; v.wr = wr; v.wd = wd; v.inp = inp;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    write   = 1'b0;
    tick();
    chk(name, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; address = 2'd0; writedata = '0; in_port = '0;
    reset2 = 1'b1; write2 = 1'b0; address2 = 2'd0; writedata2 = '0; in_port2 = '0;

    // Each row is applied before an edge and checked just after it. readdata shows the
    // register value held before that edge. Rows 5.. hold in_port=1 from edge k (row 5):
    // sync=1 after k+1, deb=1 after k+5, capture bit0 after k+6.
    vecs[0]  = mk(1'b1, 2'd0, 1'b0, 32'h0,   10'h000, 32'h000, 1'b0);
    vecs[1]  = mk(1'b0, 2'd0, 1'b0, 32'h0,   10'h000, 32'h000, 1'b0);
    vecs[2]  = mk(1'b0, 2'd1, 1'b0, 32'h0,   10'h000, 32'h000, 1'b0);
    vecs[3]  = mk(1'b0, 2'd2, 1'b0, 32'h0,   10'h000, 32'h000, 1'b0);
    vecs[4]  = mk(1'b0, 2'd3, 1'b0, 32'h0,   10'h000, 32'h000, 1'b0);
    vecs[5]  = mk(1'b0, 2'd3, 1'b0, 32'h0,   10'h001, 32'h000, 1'b0); // k
    vecs[6]  = mk(1'b0, 2'd3, 1'b0, 32'h0,   10'h001, 32'h000, 1'b0); // k+1
    vecs[7]  = mk(1'b0, 2'd3, 1'b0, 32'h0,   10'h001, 32'h001, 1'b0); // raw visible
    vecs[8]  = mk(1'b0, 2'd0, 1'b0, 32'h0,   10'h001, 32'h000, 1'b0);
    vecs[9]  = mk(1'b0, 2'd0, 1'b0, 32'h0,   10'h001, 32'h000, 1'b0);
    vecs[10] = mk(1'b0, 2'd0, 1'b0, 32'h0,   10'h001, 32'h000, 1'b0); // k+5: deb updates
    vecs[11] = mk(1'b0, 2'd0, 1'b0, 32'h0,   10'h001, 32'h001, 1'b0); // k+6: cap set
    vecs[12] = mk(1'b0, 2'd2, 1'b0, 32'h0,   10'h001, 32'h001, 1'b0); // masked, irq 0
    vecs[13] = mk(1'b0, 2'd1, 1'b1, 32'h1,   10'h001, 32'h000, 1'b1); // mask write
    vecs[14] = mk(1'b0, 2'd1, 1'b0, 32'h0,   10'h001, 32'h001, 1'b1);
    vecs[15] = mk(1'b0, 2'd2, 1'b1, 32'h1,   10'h001, 32'h001, 1'b0); // W1C
    vecs[16] = mk(1'b0, 2'd2, 1'b0, 32'h0,   10'h001, 32'h000, 1'b0);
    vecs[17] = mk(1'b0, 2'd0, 1'b1, 32'h3FF, 10'h001, 32'h001, 1'b0); // data is read-only
    vecs[18] = mk(1'b0, 2'd0, 1'b0, 32'h0,   10'h001, 32'h001, 1'b0);

    for (int i = 0; i < 19; i++) begin
      reset = vecs[i].rst; address = vecs[i].addr; write = vecs[i].wr;
      writedata = vecs[i].wd; in_port = vecs[i].inp;
      tick();
      chk($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end
    write = 1'b0;

    // 3-cycle glitch on bit3: raw shows it, deb and capture do not.
    in_port = 10'h009; address = 2'd3;
    tick(); tick(); tick();
    chk("glitch raw", readdata, 32'h009);
    in_port = 10'h001;
    repeat (8) tick();
    rd_chk("glitch deb", 2'd0, 32'h001);
    rd_chk("glitch cap", 2'd2, 32'h000);

    // 4-cycle pulse on bit3 is accepted.
    in_port = 10'h009; address = 2'd0;
    repeat (4) tick();
    in_port = 10'h001;
    tick(); tick(); tick();
    chk("pulse deb", readdata, 32'h009);
    repeat (8) tick();
    rd_chk("pulse cap", 2'd2, 32'h008);
    chk("pulse irq masked", {31'b0, irq}, 32'h0);
    rd_chk("pulse deb settled", 2'd0, 32'h001);

    // Rise on bit2 from edge p is captured at p+6; W1C of bits 3:2 lands on that same edge.
    in_port = 10'h005;
    tick();
    repeat (5) tick();
    address = 2'd2; write = 1'b1; writedata = 32'h00C;
    tick();
    chk("w1c pre", readdata, 32'h008);
    write = 1'b0;
    tick();
    chk("set wins over w1c", readdata, 32'h004);
    address = 2'd1; write = 1'b1; writedata = 32'h004;
    tick();
    write = 1'b0;
    chk("irq on mask", {31'b0, irq}, 32'h1);

    // Falling edges are ignored in rising mode.
    address = 2'd2; write = 1'b1; writedata = 32'h3FF;
    tick();
    write = 1'b0; in_port = 10'h000;
    repeat (10) tick();
    rd_chk("fall ignored cap", 2'd2, 32'h000);
    chk("fall ignored irq", {31'b0, irq}, 32'h0);
    rd_chk("fall deb", 2'd0, 32'h000);

    // Any-edge instance: bit9 rise then fall each set the capture bit.
    reset2 = 1'b0; in_port2 = 10'h200;
    repeat (9) tick();
    address2 = 2'd2;
    tick();
    chk("any rise cap", readdata2, 32'h200);
    address2 = 2'd1; write2 = 1'b1; writedata2 = 32'h3FF;
    tick();
    write2 = 1'b0;
    chk("any irq", {31'b0, irq2}, 32'h1);
    address2 = 2'd2; write2 = 1'b1; writedata2 = 32'h200;
    tick();
    write2 = 1'b0;
    chk("any w1c irq", {31'b0, irq2}, 32'h0);
    in_port2 = 10'h000;
    repeat (9) tick();
    chk("any fall cap", readdata2, 32'h200);
    chk("any fall irq", {31'b0, irq2}, 32'h1);

    // Reset mid-debounce, then an input held high yields a fresh rising edge.
    in_port2 = 10'h001;
    repeat (3) tick();
    reset2 = 1'b1; address2 = 2'd0;
    tick();
    chk("rst readdata", readdata2, 32'h0);
    chk("rst irq", {31'b0, irq2}, 32'h0);
    reset2 = 1'b0;
    repeat (5) tick();
    tick();
    chk("post rst deb early", readdata2, 32'h000);
    tick();
    chk("post rst deb", readdata2, 32'h001);
    address2 = 2'd2;
    tick();
    chk("post rst cap", readdata2, 32'h001);
    address2 = 2'd1;
    tick();
    chk("post rst mask", readdata2, 32'h000);
    chk("post rst irq", {31'b0, irq2}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
